// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb memory arbiter: FSM states, requester IDs
// and the fetch-starvation threshold.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Requester IDs double as bit positions in the per-requester vectors.
    typedef enum logic [1:0] {
        REQ_I    = 2'd0,
        REQ_D    = 2'd1,
        REQ_L    = 2'd2,
        REQ_NONE = 2'd3
    } req_id_t;

    localparam int NUM_REQ    = 3;
    localparam int STARVE_MAX = 4;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter: counts denied fetch cycles in RUN and requests a
// one-cycle fetch override once the threshold is reached.
module arb_starve_cnt
    import mem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    input  logic starved,
    input  logic granted,
    output logic force_fetch
);

    logic [STARVE_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (granted) begin
            count_reg <= '0;
        end else if (count_en && starved && (count_reg != STARVE_W'(STARVE_MAX))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign force_fetch = (count_reg == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter between CPU fetch, CPU data and an external loader.
// Define MEM_ARB_STARVE_EN to enable the fetch starvation override.
module mem_arb
    import mem_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_mode,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        cpu_hold
);

    state_t               state_reg;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   we_vec;
    logic [31:0]          addr_vec  [NUM_REQ];
    logic [31:0]          wdata_vec [NUM_REQ];
    logic [NUM_REQ-1:0]   rd_owner_reg;
    logic [NUM_REQ-1:0]   rvalid_vec;
    logic [31:0]          rdata_vec [NUM_REQ];
    logic                 force_fetch;

    assign we_vec    = {l_we, d_we, 1'b0};
    assign addr_vec  = '{i_addr, d_addr, l_addr};
    assign wdata_vec = '{32'h0, d_wdata, l_wdata};

`ifdef MEM_ARB_STARVE_EN
    arb_starve_cnt u_starve (
        .clock       (clock),
        .reset       (reset),
        .count_en    (state_reg == ST_RUN),
        .starved     (i_req && !gnt[REQ_I]),
        .granted     (gnt[REQ_I]),
        .force_fetch (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // Grants are held off while reset is asserted so nothing reaches memory.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            case (state_reg)
                ST_RUN: begin
                    if (i_req && (force_fetch || !d_req)) begin
                        gnt[REQ_I] = 1'b1;
                    end else if (d_req) begin
                        gnt[REQ_D] = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_mode && l_req) begin
                        gnt[REQ_L] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_we    = 1'b0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                m_we    = we_vec[k];
                m_addr  = addr_vec[k];
                m_wdata = wdata_vec[k];
            end
        end
    end

    assign m_en  = |gnt;
    assign i_gnt = gnt[REQ_I];
    assign d_gnt = gnt[REQ_D];
    assign l_gnt = gnt[REQ_L];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            rd_owner_reg <= '0;
        end else begin
            rd_owner_reg <= gnt & ~we_vec;
            case (state_reg)
                ST_RUN:   if (load_mode) state_reg <= ST_DRAIN;
                ST_DRAIN: state_reg <= load_mode ? ST_LOAD : ST_RUN;
                ST_LOAD:  if (!load_mode) state_reg <= ST_RUN;
                default:  state_reg <= ST_RUN;
            endcase
        end
    end

    // Read return path: reset cancels a return that would land this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ret
            logic [31:0] rdata_hold_reg;

            assign rvalid_vec[gi] = rd_owner_reg[gi] && !reset;

            always_ff @(posedge clock) begin
                if (reset) begin
                    rdata_hold_reg <= 32'h0;
                end else if (rvalid_vec[gi]) begin
                    rdata_hold_reg <= m_rdata;
                end
            end

            assign rdata_vec[gi] = rvalid_vec[gi] ? m_rdata : rdata_hold_reg;
        end
    endgenerate

    assign i_rvalid = rvalid_vec[REQ_I];
    assign d_rvalid = rvalid_vec[REQ_D];
    assign l_rvalid = rvalid_vec[REQ_L];
    assign i_rdata  = rdata_vec[REQ_I];
    assign d_rdata  = rdata_vec[REQ_D];
    assign l_rdata  = rdata_vec[REQ_L];

    assign cpu_hold = !reset && ((state_reg != ST_RUN) || (i_req && !gnt[REQ_I]));

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a memory model answers reads, a scoreboard
// queue holds expected read returns, and one task per scenario checks grants.
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_mode;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        l_req, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        cpu_hold;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_arb dut (
        .clock(clock), .reset(reset), .load_mode(load_mode),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .cpu_hold(cpu_hold)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // Memory model: one-cycle read latency, writes land at the edge.
    always @(posedge clock) begin
        if (m_en) begin
            if (m_we) mem[m_addr] = m_wdata;
            else m_rdata <= mem.exists(m_addr) ? mem[m_addr] : fill(m_addr);
        end
    end

    // Scoreboard consumer: every rvalid must match the oldest expected return.
    always @(negedge clock) begin
        logic [2:0]  rv;
        logic [31:0] got;
        exp_t        e;
        rv  = {l_rvalid, d_rvalid, i_rvalid};
        got = rv[0] ? i_rdata : (rv[1] ? d_rdata : l_rdata);
        if (rv != 3'b000) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL rvalid_unexpected: got rvalid=%b data=%h, required no rvalid", rv, got);
            end else begin
                e = sb_q.pop_front();
                if (rv !== (3'b001 << e.id) || got !== e.data) begin
                    n_bad++;
                    $display("FAIL read_return: got rvalid=%b data=%h, required rvalid=%b data=%h",
                             rv, got, 3'b001 << e.id, e.data);
                end else begin
                    $display("txn return id=%0d data=%h", e.id, got);
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        load_mode = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, i_rvalid, d_rvalid, l_rvalid, m_en, m_we, cpu_hold} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got gnt/rvalid/m_en/m_we/hold=%b, required 000000000",
                     {i_gnt, d_gnt, l_gnt, i_rvalid, d_rvalid, l_rvalid, m_en, m_we, cpu_hold});
        end
        n_cmp++;
        if ({i_rdata, d_rdata, l_rdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h %h %h, required all zero", i_rdata, d_rdata, l_rdata);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, m_en, m_we, cpu_hold} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_release: got gnt/m_en/m_we/hold=%b, required 000000",
                     {i_gnt, d_gnt, l_gnt, m_en, m_we, cpu_hold});
        end
        $display("txn reset done");
        next_cycle();
    endtask

    task automatic test_fetch;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, m_en, m_we} !== 5'b10010 || m_addr !== 32'h10 || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_grant: got gnt/en/we=%b addr=%h hold=%b, required 10010 addr=00000010 hold=0",
                     {i_gnt, d_gnt, l_gnt, m_en, m_we}, m_addr, cpu_hold);
        end
        sb_q.push_back('{REQ_I, ref_read(32'h10)});
        $display("txn fetch read addr=%h", i_addr);
        next_cycle();
        i_req = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_return: got rvalid=%b rdata=%h hold=%b, required 1 deadbeef 0",
                     i_rvalid, i_rdata, cpu_hold);
        end
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL fetch_hold: got rvalid=%b rdata=%h, required 0 deadbeef", i_rvalid, i_rdata);
        end
        next_cycle();
    endtask

    task automatic test_priority;
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hAB;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, m_en, m_we} !== 5'b01011 || m_addr !== 32'h400 ||
            m_wdata !== 32'hAB || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_write: got gnt/en/we=%b addr=%h wdata=%h hold=%b, required 01011 00000400 000000ab 1",
                     {i_gnt, d_gnt, l_gnt, m_en, m_we}, m_addr, m_wdata, cpu_hold);
        end
        ref_mem[32'h400] = 32'hAB;
        $display("txn data write addr=%h data=%h", d_addr, d_wdata);
        next_cycle();
        i_req = 1'b0; d_we = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, m_en, m_we} !== 4'b0110 || m_addr !== 32'h400) begin
            n_bad++;
            $display("FAIL prio_readback: got gnt/en/we=%b addr=%h, required 0110 00000400",
                     {i_gnt, d_gnt, m_en, m_we}, m_addr);
        end
        sb_q.push_back('{REQ_D, ref_read(32'h400)});
        $display("txn data read addr=%h", d_addr);
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            if (k % 2 == 0) begin
                a = 32'h100 + 32'(4 * (k / 2));
                d_req = 1'b1; d_addr = a;
                d_we = (k == 2); d_wdata = 32'h1111_0000 + 32'(k);
            end else begin
                a = 32'h200 + 32'(4 * k);
                i_req = 1'b1; i_addr = a;
            end
            if (k == 4) begin
                d_addr = 32'h104; a = 32'h104;
            end
            @(negedge clock);
            n_cmp++;
            if (i_gnt !== (k % 2 == 1) || d_gnt !== (k % 2 == 0) || m_en !== 1'b1 || m_addr !== a) begin
                n_bad++;
                $display("FAIL b2b_grant%0d: got i/d/en=%b%b%b addr=%h, required %b%b1 addr=%h",
                         k, i_gnt, d_gnt, m_en, m_addr, k % 2 == 1, k % 2 == 0, a);
            end
            if (k == 2) ref_mem[a] = d_wdata;
            else sb_q.push_back('{(k % 2 == 0) ? REQ_D : REQ_I, ref_read(a)});
            $display("txn b2b k=%0d addr=%h", k, a);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starve;
        logic exp_i;
        for (int c = 0; c < 6; c++) begin
            i_req = 1'b1; i_addr = 32'h300;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500 + 32'(4 * c);
`ifdef MEM_ARB_STARVE_EN
            exp_i = (c == 4);
`else
            exp_i = 1'b0;
`endif
            @(negedge clock);
            n_cmp++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i || cpu_hold !== !exp_i) begin
                n_bad++;
                $display("FAIL starve_c%0d: got i_gnt=%b d_gnt=%b hold=%b, required %b %b %b",
                         c, i_gnt, d_gnt, cpu_hold, exp_i, !exp_i, !exp_i);
            end
            if (exp_i) sb_q.push_back('{REQ_I, ref_read(32'h300)});
            else sb_q.push_back('{REQ_D, ref_read(d_addr)});
            $display("txn starve c=%0d winner=%s", c, exp_i ? "i" : "d");
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_load;
        load_mode = 1'b1; d_req = 1'b1; d_addr = 32'h20;
        @(negedge clock);
        n_cmp++;
        if (d_gnt !== 1'b1 || m_addr !== 32'h20) begin
            n_bad++;
            $display("FAIL load_enter: got d_gnt=%b addr=%h, required 1 00000020", d_gnt, m_addr);
        end
        sb_q.push_back('{REQ_D, ref_read(32'h20)});
        $display("txn data read addr=%h with load_mode", d_addr);
        next_cycle();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h30; l_wdata = 32'h55;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, m_en, m_we, cpu_hold} !== 6'b000001) begin
            n_bad++;
            $display("FAIL drain: got gnt/en/we/hold=%b, required 000001",
                     {i_gnt, d_gnt, l_gnt, m_en, m_we, cpu_hold});
        end
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, m_en, m_we, cpu_hold} !== 6'b001111 ||
            m_addr !== 32'h30 || m_wdata !== 32'h55) begin
            n_bad++;
            $display("FAIL load_write: got gnt/en/we/hold=%b addr=%h wdata=%h, required 001111 00000030 00000055",
                     {i_gnt, d_gnt, l_gnt, m_en, m_we, cpu_hold}, m_addr, m_wdata);
        end
        ref_mem[32'h30] = 32'h55;
        $display("txn loader write addr=%h data=%h", l_addr, l_wdata);
        next_cycle();
        l_we = 1'b0; d_req = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({l_gnt, m_en, m_we, cpu_hold} !== 4'b1101) begin
            n_bad++;
            $display("FAIL load_read: got l_gnt/en/we/hold=%b, required 1101", {l_gnt, m_en, m_we, cpu_hold});
        end
        sb_q.push_back('{REQ_L, ref_read(32'h30)});
        $display("txn loader read addr=%h", l_addr);
        next_cycle();
        load_mode = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, m_en, cpu_hold} !== 5'b00001) begin
            n_bad++;
            $display("FAIL load_exit: got gnt/en/hold=%b, required 00001", {i_gnt, d_gnt, l_gnt, m_en, cpu_hold});
        end
        next_cycle();
        idle_inputs();
        @(negedge clock);
        n_cmp++;
        if (cpu_hold !== 1'b0 || m_en !== 1'b0) begin
            n_bad++;
            $display("FAIL load_back_run: got hold=%b en=%b, required 0 0", cpu_hold, m_en);
        end
        next_cycle();
        // Abort a load request while still draining.
        load_mode = 1'b1;
        next_cycle();
        load_mode = 1'b0; d_req = 1'b1; d_addr = 32'h40;
        @(negedge clock);
        n_cmp++;
        if ({d_gnt, m_en, cpu_hold} !== 3'b001) begin
            n_bad++;
            $display("FAIL drain_abort: got d_gnt/en/hold=%b, required 001", {d_gnt, m_en, cpu_hold});
        end
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if ({d_gnt, m_en, cpu_hold} !== 3'b110) begin
            n_bad++;
            $display("FAIL drain_return: got d_gnt/en/hold=%b, required 110", {d_gnt, m_en, cpu_hold});
        end
        sb_q.push_back('{REQ_D, ref_read(32'h40)});
        $display("txn data read addr=%h after drain abort", d_addr);
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clock);
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL midread_grant: got i_gnt=%b, required 1", i_gnt);
        end
        $display("txn fetch read addr=%h then reset", i_addr);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({i_rvalid, d_rvalid, l_rvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL midread_rvalid: got %b, required 000", {i_rvalid, d_rvalid, l_rvalid});
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({i_gnt, d_gnt, l_gnt, i_rvalid, d_rvalid, l_rvalid, m_en, m_we, cpu_hold} !== 9'b0 ||
            {i_rdata, d_rdata, l_rdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL midread_after: got ctrl=%b rdata=%h %h %h, required 000000000 and zero rdata",
                     {i_gnt, d_gnt, l_gnt, i_rvalid, d_rvalid, l_rvalid, m_en, m_we, cpu_hold},
                     i_rdata, d_rdata, l_rdata);
        end
        next_cycle();
    endtask

    initial begin
        mem[32'h10]     = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        test_reset();
        test_fetch();
        test_priority();
        test_back_to_back();
        test_starve();
        test_load();
        test_reset_mid_read();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d pending returns, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 load_mode  in  1  1 = external loader owns memory, CPU held.
REQ-004 i_req / i_addr  in  1 / 32  CPU instruction-fetch read request and word address.
REQ-005 i_gnt / i_rvalid / i_rdata  out  1 / 1 / 32  fetch grant, read-return strobe, read data.
REQ-006 d_req / d_we / d_addr / d_wdata  in  1 / 1 / 32 / 32  CPU data-port request, write enable, address, write data.
REQ-007 d_gnt / d_rvalid / d_rdata  out  1 / 1 / 32  data grant, read-return strobe, read data.
REQ-008 l_req / l_we / l_addr / l_wdata  in  1 / 1 / 32 / 32  loader request, write enable, address, write data.
REQ-009 l_gnt / l_rvalid / l_rdata  out  1 / 1 / 32  loader grant, read-return strobe, read data.
REQ-010 m_en / m_we / m_addr / m_wdata  out  1 / 1 / 32 / 32  single-port memory command.
REQ-011 m_rdata  in  32  memory read data, valid one cycle after m_en & !m_we.
REQ-012 cpu_hold  out  1  1 = CPU pipeline shall not advance (drives pcpu enable low).

Function
REQ-013 At most one grant (i_gnt, d_gnt, l_gnt) SHALL be high per cycle; grants are combinational from state and requests.
REQ-014 Granted requester's command SHALL drive m_en=1, m_we, m_addr, m_wdata in the same cycle; with no grant m_en=0, m_we=0.
REQ-015 Read latency SHALL be 1: owner's *_rvalid=1 and *_rdata=m_rdata exactly one cycle after a granted read; writes produce no rvalid.
REQ-016 A grant SHALL be issuable every cycle (back-to-back, no bubble).
REQ-017 FSM states RUN, DRAIN, LOAD; reset state RUN.
REQ-018 RUN: priority d > i; loader never granted.
REQ-019 RUN -> DRAIN when load_mode=1; DRAIN issues no grant for one cycle (outstanding read returns), then -> LOAD.
REQ-020 LOAD: only loader granted; LOAD -> RUN when load_mode=0, same cycle l_req ignored.
REQ-021 DRAIN with load_mode=0 SHALL return to RUN next cycle.
REQ-022 cpu_hold=1 in DRAIN and LOAD, and in RUN when i_req=1 and i_gnt=0; else 0.
REQ-023 rdata outputs SHALL hold last returned value when rvalid=0.

Reset
REQ-024 On reset: state RUN, all grants 0, all rvalid 0, all rdata 32'h0, m_en=0, m_we=0, starvation count 0, cpu_hold=0.
REQ-025 Reset mid-read SHALL suppress the pending rvalid in the following cycle.

Configuration
REQ-026 Macro MEM_ARB_STARVE_EN defined: fetch starvation counter counts cycles with i_req=1 & i_gnt=0 in RUN; at STARVE_MAX (4) fetch SHALL win over d for one cycle, counter clears on any i_gnt.
REQ-027 Macro undefined: strict d > i priority, no counter logic present.

Structure
REQ-028 Shared package mem_arb_pkg holds FSM state encoding, requester IDs (REQ_I, REQ_D, REQ_L) and STARVE_MAX.
REQ-029 Starvation counter SHALL be sub-module arb_starve_cnt, instantiated only under MEM_ARB_STARVE_EN.

Verification
REQ-030 i_req=1, i_addr=32'h10, m_rdata=32'hDEAD_BEEF next cycle -> i_gnt=1, then i_rvalid=1, i_rdata=32'hDEADBEEF, cpu_hold=0.
REQ-031 i_req=1 and d_req=1, d_we=1, d_addr=32'h400, d_wdata=32'hAB same cycle -> d_gnt=1, m_we=1, m_addr=32'h400, i_gnt=0, cpu_hold=1.
REQ-032 d_req held 1 for 6 cycles with i_req=1, STARVE_EN defined -> i_gnt=1 on 5th cycle; undefined -> i_gnt=0 all 6 cycles.
REQ-033 load_mode=1 during outstanding d read -> d_rvalid next cycle, one DRAIN cycle with no grant, then l_gnt=1 for l_req; cpu_hold=1 throughout.
REQ-034 reset=1 in cycle after granted read -> no rvalid, all outputs at reset values next edge.
